// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared defaults, the BCD ceiling and the FSM state set for the sequential
// binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    localparam int WIDTH_DEF  = 20;
    localparam int DIGITS_DEF = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Largest value representable with the given number of decimal digits.
    function automatic longint unsigned bcd_max_f(input int digits);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam longint unsigned BCD_MAX = bcd_max_f(DIGITS_DEF);

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added
// before the shift so that it carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Add-3 correction, 4-bit wrap with no carry out.
    always_comb begin
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per clock.
// bcd/ovf only change on the final shift so the display never sees partials.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;
    localparam logic [63:0] MAX_L = bcd_max_f(DIGITS);

    state_e             state_r;
    logic [CW-1:0]      cnt_r;
    logic [SW-1:0]      scratch_r;
    logic [WIDTH-1:0]   operand_r;
    logic               ovf_lat_r;
    logic [SW-1:0]      bcd_r;
    logic               ovf_r;
    logic               done_r;

    logic [SW-1:0]      adj_s;
    logic [SW-1:0]      shifted_s;
    logic               over_s;
    logic [WIDTH-1:0]   load_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (scratch_r[4*g +: 4]),
            .adjusted (adj_s[4*g +: 4])
        );
    end

    // Operand clamp to the largest displayable value, plus the next scratch.
    always_comb begin
        over_s    = 64'(bin) > MAX_L;
        shifted_s = {adj_s[SW-2:0], operand_r[WIDTH-1]};
        if (over_s) begin
            load_s = WIDTH'(MAX_L);
        end else begin
            load_s = bin;
        end
    end

    // Conversion FSM, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            scratch_r <= '0;
            operand_r <= '0;
            ovf_lat_r <= 1'b0;
            bcd_r     <= '0;
            ovf_r     <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= SHIFT;
                        scratch_r <= '0;
                        cnt_r     <= CW'(WIDTH);
                        operand_r <= load_s;
                        ovf_lat_r <= over_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch_r <= shifted_s;
                    operand_r <= {operand_r[WIDTH-2:0], 1'b0};
                    cnt_r     <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        bcd_r   <= shifted_s;
                        ovf_r   <= ovf_lat_r;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r == SHIFT);
    assign done = done_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq against a decimal
// arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 20;
    localparam int DIGITS = 6;
    localparam int LAT    = WIDTH;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    int checks;
    int errors;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: clamp to 999999 then peel decimal digits with / and %.
    function automatic logic [4*DIGITS-1:0] model_bcd(input longint unsigned v);
        logic [4*DIGITS-1:0] r;
        longint unsigned     x;
        x = (v > 64'd999999) ? 64'd999999 : v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 64'd10);
            x = x / 64'd10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until done, bounded; cyc is edges since the start edge.
    task automatic wait_done(output int cyc, output logic held);
        logic [4*DIGITS-1:0] prev;
        prev = bcd;
        held = 1'b1;
        cyc  = 0;
        while (!done && cyc < LAT + 20) begin
            if (bcd !== prev) held = 1'b0;
            tick();
            cyc++;
        end
    endtask

    // Accept start at the next edge, then check latency, hold and result.
    task automatic run_conv(input logic [WIDTH-1:0] v, input string tag);
        int   cyc;
        logic held;
        start = 1'b1;
        bin   = v;
        tick();
        start = 1'b0;
        bin   = WIDTH'($urandom);
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(cyc, held);
        check_val({tag, "_lat"}, 64'(cyc), 64'(LAT));
        check_val({tag, "_hold"}, 64'(held), 64'd1);
        check_val({tag, "_bcd"}, 64'(bcd), 64'(model_bcd(64'(v))));
        check_val({tag, "_ovf"}, 64'(ovf), (64'(v) > 64'd999999) ? 64'd1 : 64'd0);
        check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int   cyc;
        int   ndone;
        logic held;
        logic [WIDTH-1:0] v;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        bin    = '0;
        rst_n  = 1'b0;
        #2;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_bcd", 64'(bcd), 64'd0);
        check_val("rst_ovf", 64'(ovf), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_conv(20'd0, "zero");
        tick();
        check_val("zero_pulse", 64'(done), 64'd0);
        run_conv(20'd123456, "d123456");
        run_conv(20'd999999, "d999999");
        run_conv(20'd1048575, "max_in");
        run_conv(20'd42, "after_ovf");
        run_conv(20'd1000000, "just_over");

        // Start during SHIFT must be ignored.
        start = 1'b1;
        bin   = 20'd500;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        bin   = 20'd7;
        tick();
        start = 1'b0;
        wait_done(cyc, held);
        check_val("ign_lat", 64'(cyc + 5), 64'(LAT));
        check_val("ign_bcd", 64'(bcd), 64'h000500);
        ndone = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            tick();
            if (done) ndone++;
        end
        check_val("ign_single", 64'(ndone), 64'd0);
        check_val("ign_idle", 64'(busy), 64'd0);

        // Reset mid-conversion aborts with no later done.
        start = 1'b1;
        bin   = 20'd777777;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_bcd", 64'(bcd), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check_val("abort_quiet", 64'(ndone), 64'd0);

        // Back-to-back: start on the done cycle gives the next result 21 later.
        run_conv(20'd2, "b2b_first");
        start = 1'b1;
        bin   = 20'd1;
        tick();
        start = 1'b0;
        wait_done(cyc, held);
        check_val("b2b_gap", 64'(cyc + 1), 64'(LAT + 1));
        check_val("b2b_bcd", 64'(bcd), 64'h000001);
        check_val("b2b_hold", 64'(held), 64'd1);

        // Random operands with random 0..2 cycle gaps.
        for (int n = 0; n < 40; n++) begin
            v = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            if (n % 8 == 0) v = WIDTH'($urandom_range(999990, 1000010));
            run_conv(v, "rand");
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                if (g == 0) check_val("rand_pulse", 64'(done), 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
